// File: rtl/hazard_mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_mem_controller_if
// Description : Signal bundle between the RV32I pipeline and the hazard /
//               data-memory sequencing controller.
//               slave  modport : used by hazard_mem_controller
//               master modport : used by the pipeline (or a testbench)
// Ports (all carried in the bundle):
//   Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  register indices per stage
//   RegWriteM, RegWriteW                   register-write enables in M / W
//   ResultSrcE0                            instruction in E is a load
//   PCSrcE                                 branch/jump resolved taken in E
//   MemReqM, DMemReady                     memory op in M / memory done
//   StallF/D/E/M, FlushD/E/W               pipeline register control
//   ForwardAE, ForwardBE                   ALU operand forwarding selects
//   DMemReq, MemErr                        memory request / sticky error
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_mem_controller_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  ResultSrcE0;
  logic                  PCSrcE;
  logic                  MemReqM;
  logic                  DMemReady;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushW;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  DMemReq;
  logic                  MemErr;

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, DMemReady,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, DMemReq, MemErr
  );

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, DMemReady,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, DMemReq, MemErr
  );
endinterface
`default_nettype wire

// File: rtl/hazard_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_mem_controller
// Description : Pipeline sequencing controller for the 5-stage RV32I core.
//               Generates forwarding selects, load-use stall, control-hazard
//               flushes, and runs a req/ready handshake with data memory that
//               freezes the whole pipeline while a load/store in M completes.
// Ports       : clk   - pipeline clock, rising edge
//               rst_n - asynchronous active-low reset
//               hz    - hazard_mem_controller_if.slave bundle (see interface)
// Parameters  : REG_ADDR_W     - register index width
//               TIMEOUT_CYCLES - WAIT cycles before error (timeout build only)
// Options     : define HAZ_TIMEOUT_EN to enable the WAIT timeout counter and
//               the sticky ERR state; without it WAIT waits forever and
//               MemErr is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_mem_controller #(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_mem_controller_if.slave  hz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
`ifdef HAZ_TIMEOUT_EN
    ,
    S_ERR  = 2'd3
`endif
  } state_t;

  // Elaboration-time sanity check on the configuration.
  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Local copies of the register indices; any width disagreement between the
  // bundle and REG_ADDR_W shows up here.
  logic [REG_ADDR_W-1:0] w_rs1d, w_rs2d, w_rs1e, w_rs2e, w_rde, w_rdm, w_rdw;
  assign w_rs1d = hz.Rs1D;
  assign w_rs2d = hz.Rs2D;
  assign w_rs1e = hz.Rs1E;
  assign w_rs2e = hz.Rs2E;
  assign w_rde  = hz.RdE;
  assign w_rdm  = hz.RdM;
  assign w_rdw  = hz.RdW;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_dmem_req;
  logic       w_freeze;
  logic       w_lw_stall;
  logic       w_lw_eff;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

`ifdef HAZ_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  // The cycle on which the counter would reach TIMEOUT_CYCLES.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_mem_err;
`endif

  // --------------------------------------------------------------------------
  // Forwarding: M stage has priority over W; x0 is never forwarded.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fwd_a = 2'b00;
    if (hz.RegWriteM && (w_rdm != '0) && (w_rdm == w_rs1e)) begin
      w_fwd_a = 2'b10;
    end else if (hz.RegWriteW && (w_rdw != '0) && (w_rdw == w_rs1e)) begin
      w_fwd_a = 2'b01;
    end
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (hz.RegWriteM && (w_rdm != '0) && (w_rdm == w_rs2e)) begin
      w_fwd_b = 2'b10;
    end else if (hz.RegWriteW && (w_rdw != '0) && (w_rdw == w_rs2e)) begin
      w_fwd_b = 2'b01;
    end
  end

  // Load in E whose destination is read by the instruction in D.
  assign w_lw_stall = hz.ResultSrcE0 && (w_rde != '0) &&
                      ((w_rde == w_rs1d) || (w_rde == w_rs2d));
  // During a freeze the load stays in E, so its hazard is resolved later.
  assign w_lw_eff   = w_lw_stall && !w_freeze;

  // --------------------------------------------------------------------------
  // Memory handshake FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_freeze     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hz.MemReqM) begin
          w_freeze     = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_freeze = 1'b1;
        if (hz.DMemReady) begin
          w_next_state = S_DONE;
`ifdef HAZ_TIMEOUT_EN
        end else if (r_cnt == c_cnt_last) begin
          w_next_state = S_ERR;
`endif
        end
      end
      // Pipeline advances on this edge; back to IDLE so consecutive ops are
      // separated by a cycle with DMemReq low.
      S_DONE: begin
        w_next_state = S_IDLE;
      end
`ifdef HAZ_TIMEOUT_EN
      S_ERR: begin
        w_freeze = 1'b1;
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dmem_req <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      // Registered request: high for exactly the cycles spent in WAIT.
      r_dmem_req <= (w_next_state == S_WAIT);
    end
  end

`ifdef HAZ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if ((r_state == S_WAIT) && !hz.DMemReady) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_next_state == S_ERR) begin
        r_mem_err <= 1'b1;
      end
    end
  end
  assign hz.MemErr = r_mem_err;
`else
  assign hz.MemErr = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs. All pipeline controls are forced low while reset is asserted.
  // A taken branch overrides the load-use stall (the load's consumer is
  // being flushed anyway); a freeze overrides both and defers the flush.
  // --------------------------------------------------------------------------
  assign hz.StallF    = rst_n && (w_freeze || (w_lw_eff && !hz.PCSrcE));
  assign hz.StallD    = rst_n && (w_freeze || (w_lw_eff && !hz.PCSrcE));
  assign hz.StallE    = rst_n && w_freeze;
  assign hz.StallM    = rst_n && w_freeze;
  assign hz.FlushD    = rst_n && !w_freeze && hz.PCSrcE;
  assign hz.FlushE    = rst_n && !w_freeze && (hz.PCSrcE || w_lw_stall);
  assign hz.FlushW    = rst_n && w_freeze;
  assign hz.ForwardAE = rst_n ? w_fwd_a : 2'b00;
  assign hz.ForwardBE = rst_n ? w_fwd_b : 2'b00;
  assign hz.DMemReq   = r_dmem_req;

endmodule
`default_nettype wire

// File: tb/tb_hazard_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_mem_controller
// Description : Directed self-checking bench for hazard_mem_controller:
//               reset, forwarding, load-use, branch flush, memory handshake,
//               deferred branch, back-to-back ops, timeout / long wait and
//               reset during an access.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_mem_controller;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  hazard_mem_controller_if #(.REG_ADDR_W(5)) hz ();

  hazard_mem_controller #(
    .REG_ADDR_W     (5),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.DMemReady = 1'b0;
  endtask

  task automatic check_frozen(input string tag);
    check({tag, ".StallF"}, hz.StallF, 1);
    check({tag, ".StallM"}, hz.StallM, 1);
    check({tag, ".FlushW"}, hz.FlushW, 1);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clear_inputs();

    // ---------------- reset forces all outputs low ----------------
    rst_n = 1'b0;
    hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1; hz.RegWriteM = 1'b1;
    hz.RdM = 5'd5; hz.Rs1E = 5'd5;
    #3;
    check("rst.StallF",    hz.StallF, 0);
    check("rst.FlushD",    hz.FlushD, 0);
    check("rst.ForwardAE", hz.ForwardAE, 0);
    check("rst.DMemReq",   hz.DMemReq, 0);
    check("rst.MemErr",    hz.MemErr, 0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- forwarding ----------------
    hz.RdM = 5'd5; hz.RdW = 5'd5; hz.Rs1E = 5'd5;
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
    #1 check("fwdA.M_prio", hz.ForwardAE, 2'b10);
    hz.RegWriteM = 1'b0;
    #1 check("fwdA.W", hz.ForwardAE, 2'b01);
    hz.Rs1E = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    #1 check("fwdA.x0", hz.ForwardAE, 2'b00);
    hz.Rs2E = 5'd7; hz.RdW = 5'd7; hz.RdM = 5'd7; hz.RegWriteM = 1'b0;
    #1 check("fwdB.W", hz.ForwardBE, 2'b01);
    hz.RegWriteM = 1'b1;
    #1 check("fwdB.M", hz.ForwardBE, 2'b10);
    hz.RegWriteW = 1'b0; hz.RdM = 5'd8;
    #1 check("fwdB.none", hz.ForwardBE, 2'b00);
    clear_inputs();
    tick();

    // ---------------- load-use ----------------
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd3; hz.Rs2D = 5'd3;
    #1;
    check("lw.StallF", hz.StallF, 1);
    check("lw.StallD", hz.StallD, 1);
    check("lw.FlushE", hz.FlushE, 1);
    check("lw.StallE", hz.StallE, 0);
    check("lw.FlushD", hz.FlushD, 0);
    tick();
    hz.ResultSrcE0 = 1'b0; hz.RdE = 5'd0;  // bubble now in E
    #1;
    check("lw.after.StallF", hz.StallF, 0);
    check("lw.after.FlushE", hz.FlushE, 0);
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd0; hz.Rs2D = 5'd0;
    #1;
    check("lw.rd0.StallF", hz.StallF, 0);
    check("lw.rd0.FlushE", hz.FlushE, 0);
    // load-use together with a taken branch: flush wins
    hz.RdE = 5'd3; hz.Rs1D = 5'd3; hz.PCSrcE = 1'b1;
    #1;
    check("lwbr.StallF", hz.StallF, 0);
    check("lwbr.FlushD", hz.FlushD, 1);
    check("lwbr.FlushE", hz.FlushE, 1);
    clear_inputs();
    tick();

    // ---------------- memory handshake, ready on 3rd WAIT ----------------
    hz.MemReqM = 1'b1;
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;  // masked by freeze
    #1;
    check_frozen("mem.idle");
    check("mem.idle.StallE",  hz.StallE, 1);
    check("mem.idle.FlushE",  hz.FlushE, 0);
    check("mem.idle.DMemReq", hz.DMemReq, 0);
    tick();
    check_frozen("mem.w1");
    check("mem.w1.DMemReq", hz.DMemReq, 1);
    check("mem.w1.FlushE",  hz.FlushE, 0);
    tick();
    check_frozen("mem.w2");
    check("mem.w2.DMemReq", hz.DMemReq, 1);
    tick();
    hz.DMemReady = 1'b1;
    hz.ResultSrcE0 = 1'b0;
    #1;
    check_frozen("mem.w3");
    check("mem.w3.DMemReq", hz.DMemReq, 1);
    tick();
    hz.DMemReady = 1'b0;
    #1;
    check("mem.done.StallF",  hz.StallF, 0);
    check("mem.done.StallM",  hz.StallM, 0);
    check("mem.done.FlushW",  hz.FlushW, 0);
    check("mem.done.DMemReq", hz.DMemReq, 0);
    hz.MemReqM = 1'b0;
    tick();
    // DMemReady outside WAIT is ignored
    hz.DMemReady = 1'b1;
    tick();
    hz.DMemReady = 1'b0;
    #1;
    check("rdyidle.StallM",  hz.StallM, 0);
    check("rdyidle.DMemReq", hz.DMemReq, 0);
    clear_inputs();
    tick();

    // ---------------- deferred branch + back-to-back ----------------
    hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1;
    #1;
    check("br.idle.FlushD", hz.FlushD, 0);
    check("br.idle.FlushE", hz.FlushE, 0);
    tick();
    hz.DMemReady = 1'b1;
    #1;
    check("br.wait.FlushD", hz.FlushD, 0);
    check("br.wait.FlushE", hz.FlushE, 0);
    check("br.wait.DMemReq", hz.DMemReq, 1);
    tick();
    hz.DMemReady = 1'b0;
    #1;
    check("br.done.FlushD", hz.FlushD, 1);
    check("br.done.FlushE", hz.FlushE, 1);
    check("br.done.StallF", hz.StallF, 0);
    hz.PCSrcE = 1'b0;  // MemReqM stays high: next op already in M
    tick();
    check_frozen("b2b.idle");
    check("b2b.idle.DMemReq", hz.DMemReq, 0);
    tick();
    check("b2b.wait.DMemReq", hz.DMemReq, 1);
    hz.DMemReady = 1'b1;
    tick();
    hz.DMemReady = 1'b0; hz.MemReqM = 1'b0;
    #1 check("b2b.done.StallF", hz.StallF, 0);
    tick();

    // ---------------- ready on the limit cycle wins ----------------
    hz.MemReqM = 1'b1;
    tick(); tick(); tick(); tick();  // now in 4th WAIT cycle
    hz.DMemReady = 1'b1;
    tick();
    hz.DMemReady = 1'b0; hz.MemReqM = 1'b0;
    #1;
    check("lim.done.StallF", hz.StallF, 0);
    check("lim.done.MemErr", hz.MemErr, 0);
    tick();

`ifdef HAZ_TIMEOUT_EN
    // ---------------- timeout into ERR ----------------
    hz.MemReqM = 1'b1;
    tick(); tick(); tick(); tick();  // 4th WAIT cycle
    check("to.w4.DMemReq", hz.DMemReq, 1);
    check("to.w4.MemErr",  hz.MemErr, 0);
    tick();
    check("to.err.MemErr",  hz.MemErr, 1);
    check("to.err.DMemReq", hz.DMemReq, 0);
    check_frozen("to.err");
    hz.MemReqM = 1'b0;
    tick(); tick();
    check("to.sticky.MemErr", hz.MemErr, 1);
    check("to.sticky.StallF", hz.StallF, 1);
    #1 rst_n = 1'b0;
    #1;
    check("to.rst.MemErr", hz.MemErr, 0);
    check("to.rst.StallF", hz.StallF, 0);
    #1 rst_n = 1'b1;
    tick();
    check("to.idle.StallM", hz.StallM, 0);
    check("to.idle.MemErr", hz.MemErr, 0);
`else
    // ---------------- no timeout: WAIT persists ----------------
    hz.MemReqM = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("long.DMemReq", hz.DMemReq, 1);
    check("long.MemErr",  hz.MemErr, 0);
    check_frozen("long");
    hz.DMemReady = 1'b1;
    tick();
    hz.DMemReady = 1'b0; hz.MemReqM = 1'b0;
    #1 check("long.done.StallF", hz.StallF, 0);
    tick();
`endif

    // ---------------- reset in the middle of an access ----------------
    hz.MemReqM = 1'b1;
    tick();
    check("mrst.wait.DMemReq", hz.DMemReq, 1);
    #1 rst_n = 1'b0;
    #1 check("mrst.async.DMemReq", hz.DMemReq, 0);
    #1 rst_n = 1'b1;
    #1;
    check_frozen("mrst.idle");
    check("mrst.idle.DMemReq", hz.DMemReq, 0);
    tick();
    check("mrst.wait2.DMemReq", hz.DMemReq, 1);
    hz.DMemReady = 1'b1;
    tick();
    hz.DMemReady = 1'b0; hz.MemReqM = 1'b0;
    #1 check("mrst.done.StallF", hz.StallF, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
